// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - table-driven PWM LED sequencer with one-shot/loop/ping-pong/hold play (optional fade: LED_SEQ_FADE_EN)
module led_pattern_sequencer #(
    parameter int NCH        = 16,
    parameter int DC_BITS    = 4,
    parameter int DEPTH      = 32,
    parameter int PASSES     = 3,
    parameter int TICK_DIV   = 400,
    parameter int STEP_TICKS = 25,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PW = $clog2(PASSES + 1)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   RUN,
    input  logic                   ABORT,
    input  logic [1:0]             MODE,
    input  logic [NCH-1:0]         STATUS,
    input  logic                   WR_EN,
    input  logic [AW-1:0]          WR_ADDR,
    input  logic [NCH*DC_BITS-1:0] WR_DATA,
    output logic [NCH-1:0]         LEDS,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [AW-1:0]          STEP_ADDR,
    output logic [PW-1:0]          PASS_CNT
);

    localparam int PRW = $clog2(TICK_DIV);
    localparam int TW  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int DW  = NCH * DC_BITS;

    localparam logic [PRW-1:0]     PRE_LAST  = PRW'(TICK_DIV - 1);
    localparam logic [PRW-1:0]     PRE_ONE   = PRW'(1);
    localparam logic [TW-1:0]      TMR_LAST  = TW'(STEP_TICKS - 1);
    localparam logic [TW-1:0]      TMR_ONE   = TW'(1);
    localparam logic [DC_BITS-1:0] PH_LAST   = DC_BITS'((1 << DC_BITS) - 2);
    localparam logic [DC_BITS-1:0] PH_ONE    = DC_BITS'(1);
    localparam logic [AW-1:0]      ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0]      ADDR_ONE  = AW'(1);
    localparam logic [PW-1:0]      PASS_MAX  = PW'(PASSES);
    localparam logic [PW-1:0]      PASS_ONE  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SHOW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    logic [DW-1:0] mem_q [DEPTH];

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [PW-1:0]      pass_q, pass_d;
    logic               dir_up_q, dir_up_d;
    logic [PRW-1:0]     pre_q, pre_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [DC_BITS-1:0] phase_q, phase_d;
    logic [DW-1:0]      duty_q, duty_d;
    logic [NCH-1:0]     leds_q, leds_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef LED_SEQ_FADE_EN
    logic [DW-1:0]      target_q, target_d;
    logic               first_q, first_d;
`endif

    logic          tick;
    logic          step_end;
    logic [DW-1:0] rd_word;
    logic [PW-1:0] pass_inc;
    logic [PW-1:0] pass_wrap;

    assign tick      = (state_q == S_SHOW) && (pre_q == PRE_LAST);
    assign step_end  = tick && (tmr_q == TMR_LAST);
    assign rd_word   = mem_q[addr_q];
    assign pass_inc  = pass_q + PASS_ONE;
    assign pass_wrap = (pass_inc == PASS_MAX) ? '0 : pass_inc;

    // Pattern table: written in any state, never reset, read asynchronously
    always_ff @(posedge CLK) begin
        if (WR_EN) begin
            mem_q[WR_ADDR] <= WR_DATA;
        end
    end

    // Next-state logic for the play FSM, timers, PWM and registered outputs
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        pass_d   = pass_q;
        dir_up_d = dir_up_q;
        pre_d    = pre_q;
        tmr_d    = tmr_q;
        phase_d  = phase_q;
        duty_d   = duty_q;
        leds_d   = leds_q;
`ifdef LED_SEQ_FADE_EN
        target_d = target_q;
        first_d  = first_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (RUN && !ABORT) begin
                    mode_d   = MODE;
                    addr_d   = '0;
                    pass_d   = '0;
                    dir_up_d = 1'b1;
                    leds_d   = '0;
                    state_d  = S_LOAD;
`ifdef LED_SEQ_FADE_EN
                    first_d  = 1'b1;
`endif
                end
            end

            S_LOAD: begin
`ifdef LED_SEQ_FADE_EN
                // Fade toward the new step; only the first step of a run snaps
                target_d = rd_word;
                if (first_q) begin
                    duty_d = rd_word;
                end
                first_d  = 1'b0;
`else
                duty_d   = rd_word;
`endif
                phase_d  = '0;
                pre_d    = '0;
                tmr_d    = '0;
                state_d  = S_SHOW;
            end

            S_SHOW: begin
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
                for (int c = 0; c < NCH; c++) begin
                    leds_d[c] = (phase_q < duty_q[c*DC_BITS +: DC_BITS]);
                end
                pre_d = tick ? '0 : pre_q + PRE_ONE;
                if (tick) begin
                    tmr_d = tmr_q + TMR_ONE;
`ifdef LED_SEQ_FADE_EN
                    for (int c = 0; c < NCH; c++) begin
                        if (duty_q[c*DC_BITS +: DC_BITS] < target_q[c*DC_BITS +: DC_BITS]) begin
                            duty_d[c*DC_BITS +: DC_BITS] = duty_q[c*DC_BITS +: DC_BITS] + PH_ONE;
                        end else if (duty_q[c*DC_BITS +: DC_BITS] > target_q[c*DC_BITS +: DC_BITS]) begin
                            duty_d[c*DC_BITS +: DC_BITS] = duty_q[c*DC_BITS +: DC_BITS] - PH_ONE;
                        end
                    end
`endif
                end
                if (step_end) begin
                    state_d = S_LOAD;
                    if (mode_q == 2'd3) begin
                        // Hold: same address replayed, no pass accounting
                        addr_d = addr_q;
                    end else if ((mode_q == 2'd2) && (DEPTH > 1)) begin
                        // Ping-pong: leaving an endpoint turns around and counts a pass
                        if (dir_up_q) begin
                            if (addr_q == ADDR_LAST) begin
                                dir_up_d = 1'b0;
                                addr_d   = addr_q - ADDR_ONE;
                                pass_d   = pass_wrap;
                            end else begin
                                addr_d   = addr_q + ADDR_ONE;
                            end
                        end else begin
                            if (addr_q == '0) begin
                                dir_up_d = 1'b1;
                                addr_d   = addr_q + ADDR_ONE;
                                pass_d   = pass_wrap;
                            end else begin
                                addr_d   = addr_q - ADDR_ONE;
                            end
                        end
                    end else begin
                        // One-shot and loop (and ping-pong on a single-entry table)
                        if (addr_q == ADDR_LAST) begin
                            addr_d = '0;
                            if (mode_q == 2'd0) begin
                                pass_d = pass_inc;
                                if (pass_inc == PASS_MAX) begin
                                    state_d = S_DONE;
                                end
                            end else begin
                                pass_d = pass_wrap;
                            end
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ABORT) begin
            state_d = S_IDLE;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_SHOW);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'd0;
            addr_q   <= '0;
            pass_q   <= '0;
            dir_up_q <= 1'b1;
            pre_q    <= '0;
            tmr_q    <= '0;
            phase_q  <= '0;
            duty_q   <= '0;
            leds_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef LED_SEQ_FADE_EN
            target_q <= '0;
            first_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            pass_q   <= pass_d;
            dir_up_q <= dir_up_d;
            pre_q    <= pre_d;
            tmr_q    <= tmr_d;
            phase_q  <= phase_d;
            duty_q   <= duty_d;
            leds_q   <= leds_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef LED_SEQ_FADE_EN
            target_q <= target_d;
            first_q  <= first_d;
`endif
        end
    end

    // Live status passes straight through whenever no pattern is playing
    assign LEDS      = busy_q ? leds_q : STATUS;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign STEP_ADDR = addr_q;
    assign PASS_CNT  = pass_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - directed self-checking bench for led_pattern_sequencer
module tb_led_pattern_sequencer;

    logic       CLK;
    logic       RST_N;
    logic       RUN;
    logic       ABORT;
    logic [1:0] MODE;
    logic [3:0] STATUS;
    logic       WR_EN;
    logic [1:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic [3:0] LEDS;
    logic       BUSY;
    logic       DONE;
    logic [1:0] STEP_ADDR;
    logic [1:0] PASS_CNT;

    int checks = 0;
    int errors = 0;

    led_pattern_sequencer #(
        .NCH(4), .DC_BITS(2), .DEPTH(4), .PASSES(2), .TICK_DIV(4), .STEP_TICKS(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .ABORT(ABORT), .MODE(MODE),
        .STATUS(STATUS), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .LEDS(LEDS), .BUSY(BUSY), .DONE(DONE), .STEP_ADDR(STEP_ADDR), .PASS_CNT(PASS_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        WR_EN   = 1'b1;
        WR_ADDR = a;
        WR_DATA = d;
        tick();
        WR_EN   = 1'b0;
    endtask

    initial begin
        int done_cnt;
        int done_cyc;
        logic [1:0] pp_addr [8];
        logic [1:0] pp_pass [8];
        pp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        pp_pass = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};

        RST_N = 1'b0; RUN = 1'b0; ABORT = 1'b0; MODE = 2'd0;
        STATUS = 4'hA; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        tick();
        tick();
        chk("rst_leds", LEDS, 4'hA);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_pass", PASS_CNT, 2'd0);
        chk("rst_addr", STEP_ADDR, 2'd0);
        RST_N = 1'b1;
        tick();

        wr(2'd0, 8'hE4);
        wr(2'd1, 8'h00);
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h55);

        // Hold mode: PWM duty c on channel c
        MODE = 2'd3; RUN = 1'b1;
        tick();
        RUN = 1'b0;
        chk("pwm_busy", BUSY, 1'b1);
        tick();
        tick();
        chk("pwm_ph0", LEDS, 4'b1110);
        tick();
        chk("pwm_ph1", LEDS, 4'b1100);
        tick();
        chk("pwm_ph2", LEDS, 4'b1000);
        tick();
        chk("pwm_ph0b", LEDS, 4'b1110);
        for (int i = 7; i <= 22; i++) tick();
        chk("hold_addr", STEP_ADDR, 2'd0);
        chk("hold_pass", PASS_CNT, 2'd0);

        // Abort in the middle of SHOW
        STATUS = 4'h5; ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_done", DONE, 1'b0);
        chk("abort_leds", LEDS, 4'h5);

        // ABORT beats RUN
        ABORT = 1'b1; RUN = 1'b1;
        tick();
        ABORT = 1'b0; RUN = 1'b0;
        chk("abort_run_busy", BUSY, 1'b0);
        tick();
        chk("abort_run_busy2", BUSY, 1'b0);

        // One-shot: two passes over 4 steps of 9 cycles, DONE in cycle 73
        MODE = 2'd0; RUN = 1'b1;
        done_cnt = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            tick();
            if (cyc == 1) RUN = 1'b0;
            if (cyc == 5) MODE = 2'd1;
            if (((cyc - 1) % 9 == 0) && (cyc <= 64))
                chk($sformatf("os_addr_%0d", (cyc - 1) / 9), STEP_ADDR, ((cyc - 1) / 9) % 4);
            if (cyc == 37) chk("os_pass1", PASS_CNT, 2'd1);
            if (cyc == 73) chk("os_pass2", PASS_CNT, 2'd2);
            if (cyc == 73) chk("os_done_busy", BUSY, 1'b0);
            if (cyc == 74) chk("os_leds_status", LEDS, 4'h5);
            if (cyc == 74) chk("os_idle_busy", BUSY, 1'b0);
            if (DONE === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        chk("os_done_count", done_cnt, 1);
        chk("os_done_cycle", done_cyc, 73);

        // Ping-pong: endpoints not repeated, pass counted on leaving 3 and 0
        MODE = 2'd2; RUN = 1'b1;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 75; cyc++) begin
            tick();
            if (cyc == 1) RUN = 1'b0;
            if (((cyc - 1) % 9 == 0) && (cyc <= 64)) begin
                chk($sformatf("pp_addr_%0d", (cyc - 1) / 9), STEP_ADDR, pp_addr[(cyc - 1) / 9]);
                chk($sformatf("pp_pass_%0d", (cyc - 1) / 9), PASS_CNT, pp_pass[(cyc - 1) / 9]);
            end
            if (DONE === 1'b1) done_cnt++;
        end
        chk("pp_no_done", done_cnt, 0);
        chk("pp_still_busy", BUSY, 1'b1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("pp_abort_busy", BUSY, 1'b0);

        // Loop mode: rewrite of the showing address waits for its next LOAD
        MODE = 2'd1; RUN = 1'b1;
        for (int cyc = 1; cyc <= 75; cyc++) begin
            tick();
            if (cyc == 1) RUN = 1'b0;
            if (cyc == 13) begin
                WR_EN = 1'b1; WR_ADDR = 2'd1; WR_DATA = 8'hFF;
            end
            if (cyc == 14) begin
                WR_EN = 1'b0;
                chk("wr_addr_during", STEP_ADDR, 2'd1);
                chk("wr_old_leds_a", LEDS, 4'h0);
            end
            if (cyc == 16) chk("wr_old_leds_b", LEDS, 4'h0);
            if (cyc == 48) begin
                chk("wr_new_addr", STEP_ADDR, 2'd1);
                chk("wr_new_leds", LEDS, 4'hF);
            end
            if (cyc == 73) begin
                chk("loop_pass_wrap", PASS_CNT, 2'd0);
                chk("loop_busy", BUSY, 1'b1);
            end
        end
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("end_busy", BUSY, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
